alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 14 +
 rtl/rr_arb2.sv | 15 +
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
package alu_pkg;

  localparam int OPW  = 3;
  localparam int OPDW = 4;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters; one operation in flight,
// result held until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_opcode,
  input  logic [NREQ*OPDW-1:0] req_op1,
  input  logic [NREQ*OPDW-1:0] req_op2,
  output logic [OPW-1:0]       alu_opcode,
  output logic [OPDW-1:0]      alu_op1,
  output logic [OPDW-1:0]      alu_op2,
  input  logic [OPDW-1:0]      alu_res,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [OPDW-1:0]      rsp_res,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam logic [2:0] LatCnt = 3'(ALU_LAT);

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [OPW-1:0]  opc_q, opc_d;
  logic [OPDW-1:0] op1_q, op1_d;
  logic [OPDW-1:0] op2_q, op2_d;
  logic            id_q, id_d;
  logic [OPDW-1:0] res_q, res_d;
  logic [1:0]      gnt;

  rr_arb2 u_rr_arb2 (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Grants are gated by rstn so nothing is offered while reset is held.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    opc_d     = opc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    id_d      = id_q;
    res_d     = res_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (rstn && (gnt != 2'b00)) begin
          req_ready = gnt;
          id_d      = gnt[1];
          ptr_d     = ~gnt[1];
          opc_d     = gnt[1] ? req_opcode[5:3] : req_opcode[2:0];
          op1_d     = gnt[1] ? req_op1[7:4]    : req_op1[3:0];
          op2_d     = gnt[1] ? req_op2[7:4]    : req_op2[3:0];
          cnt_d     = LatCnt;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          res_d   = alu_res;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= 3'd0;
      opc_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

  // The capture registers feed the ALU directly, so operands persist after EXEC.
  assign alu_opcode = opc_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_res    = res_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: one arbiter with a 1-cycle combinational ALU and one with a
// 3-cycle pipelined ALU, driven from shared request inputs.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] req_valid;
  logic [5:0] req_opcode;
  logic [7:0] req_op1, req_op2;
  logic       rsp_ready;

  logic [1:0] rdy1, rdy3;
  logic [2:0] aop1, aop3;
  logic [3:0] aa1, ab1, aa3, ab3;
  logic [3:0] ares1, ares3;
  logic       rv1, rv3, rid1, rid3, busy1, busy3;
  logic [3:0] rres1, rres3;
  logic [3:0] pipe0, pipe1;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  // Reference ALU: a ^ (b << 1) ^ opcode.
  function automatic logic [3:0] aluModel(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    return a ^ {b[2:0], 1'b0} ^ {1'b0, op};
  endfunction

  assign ares1 = aluModel(aop1, aa1, ab1);

  // Two register stages: the result is only correct on the last EXEC cycle.
  always @(posedge clk) begin
    pipe0 <= aluModel(aop3, aa3, ab3);
    pipe1 <= pipe0;
  end
  assign ares3 = pipe1;

  alu_arbiter #(.ALU_LAT(1)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy1),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .alu_opcode(aop1), .alu_op1(aa1), .alu_op2(ab1), .alu_res(ares1),
    .rsp_valid(rv1), .rsp_id(rid1), .rsp_res(rres1), .rsp_ready(rsp_ready),
    .busy(busy1)
  );

  alu_arbiter #(.ALU_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy3),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .alu_opcode(aop3), .alu_op1(aa3), .alu_op2(ab3), .alu_res(ares3),
    .rsp_valid(rv3), .rsp_id(rid3), .rsp_res(rres3), .rsp_ready(rsp_ready),
    .busy(busy3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic rdy);
    req_valid = valid;
    rsp_ready = rdy;
  endtask

  task automatic loadOperands(input int idx, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    req_opcode[idx*3 +: 3] = op;
    req_op1[idx*4 +: 4]    = a;
    req_op2[idx*4 +: 4]    = b;
  endtask

  task automatic pulseReset;
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
  endtask

  task automatic waitIdle;
    for (int i = 0; i < 20; i++) begin
      if (!busy1 && !busy3) break;
      tick();
    end
    checkOutput("wait_idle", {30'd0, busy1, busy3}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants;
    int order[4];
    int gcyc[4];
    int expOrder[4] = '{0, 1, 0, 1};
    logic bothHigh, seen;

    rstn = 1'b0;
    applyStimulus(2'b00, 1'b1);
    req_opcode = '0;
    req_op1 = '0;
    req_op2 = '0;

    // Reset values, and no grant offered while reset is held.
    #12;
    checkOutput("rst_rsp_valid", rv1, 0);
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_alu", {aop1, aa1, ab1}, 0);
    checkOutput("rst_rsp", {rid1, rres1}, 0);
    req_valid = 2'b01;
    #1;
    checkOutput("rst_no_ready", rdy1, 0);
    req_valid = 2'b00;
    rstn = 1'b1;
    tick();

    // Single request from requester 0 on the 1-cycle ALU.
    loadOperands(0, 3'b011, 4'b0001, 4'b1000);
    applyStimulus(2'b01, 1'b1);
    #1;
    checkOutput("r0_ready", rdy1, 2'b01);
    tick();
    applyStimulus(2'b00, 1'b1);
    #1;
    checkOutput("r0_ready_low", rdy1, 0);
    checkOutput("r0_busy", busy1, 1);
    checkOutput("r0_alu", {aop1, aa1, ab1}, {3'b011, 4'b0001, 4'b1000});
    checkOutput("r0_no_rsp_yet", rv1, 0);
    tick();
    checkOutput("r0_rsp_valid", rv1, 1);
    checkOutput("r0_rsp_id", rid1, 0);
    checkOutput("r0_rsp_res", rres1, 4'h2);
    tick();
    checkOutput("r0_back_idle", {rv1, busy1}, 0);

    // Both requesters held: alternating grants, ALU_LAT+2 spacing.
    waitIdle();
    pulseReset();
    loadOperands(0, 3'b001, 4'h3, 4'h4);
    loadOperands(1, 3'b110, 4'h9, 4'h2);
    applyStimulus(2'b11, 1'b1);
    grants = 0;
    bothHigh = 1'b0;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      #1;
      if (rdy1 == 2'b11) bothHigh = 1'b1;
      if (rdy1 != 2'b00) begin
        order[grants] = int'(rdy1[1]);
        gcyc[grants]  = cyc;
        grants++;
      end
      tick();
    end
    applyStimulus(2'b00, 1'b1);
    checkOutput("rr_grant_count", grants, 4);
    checkOutput("rr_never_both", bothHigh, 0);
    for (int i = 0; i < 4; i++) begin
      if (i < grants) checkOutput($sformatf("rr_order%0d", i), order[i], expOrder[i]);
      if (i > 0 && i < grants) checkOutput($sformatf("rr_spacing%0d", i), gcyc[i] - gcyc[i-1], 3);
    end

    // Consumer stalls in RESP while requester 1 waits.
    waitIdle();
    loadOperands(0, 3'b100, 4'b0110, 4'b0011);
    loadOperands(1, 3'b010, 4'b1010, 4'b0101);
    applyStimulus(2'b01, 1'b1);
    #1;
    checkOutput("stall_grant0", rdy1, 2'b01);
    tick();
    applyStimulus(2'b10, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall_hold%0d", k), {rv1, rid1, rres1, busy1}, {1'b1, 1'b0, 4'h4, 1'b1});
      checkOutput($sformatf("stall_no_grant%0d", k), rdy1, 0);
      tick();
    end
    applyStimulus(2'b10, 1'b1);
    tick();
    #1;
    checkOutput("pending_req1_ready", rdy1, 2'b10);
    tick();
    applyStimulus(2'b00, 1'b1);
    tick();
    checkOutput("req1_rsp", {rv1, rid1, rres1}, {1'b1, 1'b1, 4'h2});

    // Reset asserted mid-EXEC abandons the operation.
    waitIdle();
    loadOperands(0, 3'b001, 4'b0101, 4'b0011);
    applyStimulus(2'b01, 1'b1);
    tick();
    applyStimulus(2'b00, 1'b1);
    checkOutput("midexec_busy", busy1, 1);
    rstn = 1'b0;
    #1;
    checkOutput("midexec_rst_dut1", {busy1, rv1, rid1, rres1, aop1, aa1, ab1, rdy1}, 0);
    checkOutput("midexec_rst_dut3", {busy3, rv3, aop3, aa3, ab3}, 0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (rv1 || rv3 || busy1 || busy3) seen = 1'b1;
    end
    checkOutput("midexec_no_rsp", seen, 0);

    // Three-cycle ALU, requester 1.
    loadOperands(1, 3'b000, 4'b1111, 4'b0001);
    applyStimulus(2'b10, 1'b1);
    #1;
    checkOutput("lat3_ready", rdy3, 2'b10);
    tick();
    applyStimulus(2'b00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("lat3_alu%0d", k), {aop3, aa3, ab3}, {3'b000, 4'b1111, 4'b0001});
      checkOutput($sformatf("lat3_busy_norsp%0d", k), {busy3, rv3}, 2'b10);
      tick();
    end
    checkOutput("lat3_rsp", {rv3, rid3, rres3}, {1'b1, 1'b1, 4'hD});
    tick();
    checkOutput("lat3_idle", {rv3, busy3}, 0);
    checkOutput("lat3_alu_held", {aop3, aa3, ab3}, {3'b000, 4'b1111, 4'b0001});

    // Requester 0 pulses valid during RESP, then drops out.
    waitIdle();
    loadOperands(0, 3'b101, 4'b0011, 4'b0100);
    applyStimulus(2'b01, 1'b1);
    tick();
    applyStimulus(2'b00, 1'b0);
    tick();
    applyStimulus(2'b01, 1'b0);
    #1;
    checkOutput("drop_in_resp", {rv1, rdy1}, {1'b1, 2'b00});
    tick();
    applyStimulus(2'b00, 1'b1);
    tick();
    seen = 1'b0;
    repeat (4) begin
      #1;
      if (busy1 || rdy1 != 2'b00) seen = 1'b1;
      tick();
    end
    checkOutput("drop_stays_idle", seen, 0);
    checkOutput("drop_no_rsp", rv1, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
